// File: rtl/address_generation_unit_pkg.sv
// Shared opcode, access-size and FSM state definitions for the address generation unit.
package address_generation_unit_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_e;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  function automatic logic is_ctrl_op(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
  endfunction

  // Low address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_lsb_mask(input size_e sz);
    logic [2:0] m;
    case (sz)
      SZ_BYTE:  m = 3'b000;
      SZ_HALF:  m = 3'b001;
      SZ_WORD:  m = 3'b011;
      default:  m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/address_generation_unit_byte_mask_generator.sv
// Combinational byte-lane mask over two consecutive beats, plus the beat-crossing flag.
module address_generation_unit_byte_mask_generator
  import address_generation_unit_pkg::*;
#(
  parameter int BEAT_BYTES = 4
) (
  input  logic [$clog2(BEAT_BYTES)-1:0] offset_i,
  input  size_e                         size_i,
  output logic [2*BEAT_BYTES-1:0]       mask_o,
  output logic                          cross_o
);

  localparam int MW = 2 * BEAT_BYTES;
  // Headroom so a dword shifted to the last lane of a 4-byte beat never wraps.
  localparam int WW = MW + 8;

  logic [WW-1:0]    ones;
  logic [WW-1:0]    shifted;
  logic [4:0]       nbytes;
  logic [WW-MW-1:0] unused_spill;

  always_comb begin
    ones   = WW'(8'h01);
    nbytes = 5'd1;
    case (size_i)
      SZ_BYTE:  begin ones = WW'(8'h01); nbytes = 5'd1; end
      SZ_HALF:  begin ones = WW'(8'h03); nbytes = 5'd2; end
      SZ_WORD:  begin ones = WW'(8'h0F); nbytes = 5'd4; end
      default:  begin ones = WW'(8'hFF); nbytes = 5'd8; end
    endcase
    shifted = ones << offset_i;
  end

  assign mask_o       = shifted[MW-1:0];
  assign unused_spill = shifted[WW-1:MW];
  assign cross_o      = (5'(offset_i) + nbytes) > 5'(BEAT_BYTES);

endmodule

// File: rtl/address_generation_unit.sv
// Pipelined effective-address unit: one registered output beat per request, two for
// load/store accesses that straddle a bus-beat boundary.
module address_generation_unit
  import address_generation_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int BEAT_BYTES       = 4,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       rs1,
  input  logic [XLEN-1:0]       PC,
  input  logic [XLEN-1:0]       immediate,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [XLEN-1:0]       effective_address,
  output logic [XLEN-1:0]       address,
  output logic [BEAT_BYTES-1:0] byte_enable,
  output logic                  is_memory,
  output logic                  last_beat,
  output logic                  misaligned
);

  // state   | meaning
  // S_IDLE  | no beat held
  // S_BEAT0 | first (or only) beat presented
  // S_BEAT1 | second beat of a split load/store presented

  localparam int OFFW  = $clog2(BEAT_BYTES);
  localparam int MW    = 2 * BEAT_BYTES;
  localparam bit SPLIT = (SPLIT_MISALIGNED != 0);

  logic [XLEN-1:0]       ea_c, addr_c;
  logic                  mem_c, sup_c, cross_raw_c, split_c, mis_c;
  logic [MW-1:0]         mask_c;
  logic [BEAT_BYTES-1:0] be0_c, be1_c;
  size_e                 size_c;
  logic                  unused_funct3;
  logic                  accept, load;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       ea_q, ea_d, addr_q, addr_d;
  logic [BEAT_BYTES-1:0] be_q, be_d, be1_q, be1_d;
  logic                  mem_q, mem_d, last_q, last_d, mis_q, mis_d;

  assign size_c        = size_e'(funct3[1:0]);
  assign unused_funct3 = funct3[2];

  always_comb begin
    mem_c = is_mem_op(opcode);
    sup_c = mem_c || is_ctrl_op(opcode);
    ea_c  = ((opcode == OPC_JAL) || (opcode == OPC_BRANCH)) ? PC + immediate
                                                            : rs1 + immediate;
    if (opcode == OPC_JALR) ea_c[0] = 1'b0;
  end

  address_generation_unit_byte_mask_generator #(
    .BEAT_BYTES(BEAT_BYTES)
  ) u_mask (
    .offset_i(ea_c[OFFW-1:0]),
    .size_i  (size_c),
    .mask_o  (mask_c),
    .cross_o (cross_raw_c)
  );

  always_comb begin
    split_c = SPLIT && mem_c && cross_raw_c;
    be0_c   = '0;
    be1_c   = '0;
    addr_c  = ea_c;
    mis_c   = (ea_c[1:0] != 2'b00);
    if (mem_c) begin
      be0_c  = mask_c[BEAT_BYTES-1:0];
      be1_c  = mask_c[MW-1:BEAT_BYTES];
      addr_c = {ea_c[XLEN-1:OFFW], {OFFW{1'b0}}};
      // With splitting, only a dword that can never fit one 4-byte beat is a fault.
      if (SPLIT) mis_c = (size_c == SZ_DWORD) && (BEAT_BYTES == 4);
      else       mis_c = (ea_c[2:0] & size_lsb_mask(size_c)) != 3'b000;
    end
  end

  assign ready_in = (state_q == S_IDLE) || (last_q && ready_out);
  assign accept   = valid_in && ready_in;
  assign load     = accept && sup_c;

  always_comb begin
    state_d = state_q;
    ea_d    = ea_q;
    addr_d  = addr_q;
    be_d    = be_q;
    be1_d   = be1_q;
    mem_d   = mem_q;
    last_d  = last_q;
    mis_d   = mis_q;
    case (state_q)
      S_BEAT0: begin
        if (ready_out) begin
          if (last_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_BEAT1;
            addr_d  = addr_q + XLEN'(BEAT_BYTES);
            be_d    = be1_q;
            last_d  = 1'b1;
          end
        end
      end
      S_BEAT1: begin
        if (ready_out) state_d = S_IDLE;
      end
      default: ;
    endcase
    // Accept only happens when no beat remains, so a new load overrides the retire.
    if (load) begin
      state_d = S_BEAT0;
      ea_d    = ea_c;
      addr_d  = addr_c;
      be_d    = be0_c;
      be1_d   = be1_c;
      mem_d   = mem_c;
      last_d  = !split_c;
      mis_d   = mis_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ea_q    <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      be1_q   <= '0;
      mem_q   <= 1'b0;
      last_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ea_q    <= ea_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      be1_q   <= be1_d;
      mem_q   <= mem_d;
      last_q  <= last_d;
      mis_q   <= mis_d;
    end
  end

  assign valid_out         = (state_q != S_IDLE);
  assign effective_address = ea_q;
  assign address           = addr_q;
  assign byte_enable       = be_q;
  assign is_memory         = mem_q;
  assign last_beat         = last_q;
  assign misaligned        = mis_q;

endmodule

// File: tb/tb_address_generation_unit.sv
// Scoreboard bench for address_generation_unit: a split-mode instance under directed and
// random traffic, plus a non-split instance for the single-beat misaligned case.
module tb_address_generation_unit;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'h33;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        valid_in, ready_in, valid_out, ready_out, is_memory, last_beat, misaligned;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1, pc, imm, effective_address, address;
  logic [3:0]  byte_enable;

  logic        valid_b, ready_in_b, valid_out_b, is_memory_b, last_beat_b, misaligned_b;
  logic [31:0] ea_b, address_b;
  logic [3:0]  be_b;

  logic bp_en, bp_rand, ro_force;
  assign ready_out = bp_en ? bp_rand : ro_force;

  address_generation_unit #(.XLEN(32), .BEAT_BYTES(4), .SPLIT_MISALIGNED(1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .opcode(opcode), .funct3(funct3), .rs1(rs1), .PC(pc), .immediate(imm),
    .valid_out(valid_out), .ready_out(ready_out), .effective_address(effective_address),
    .address(address), .byte_enable(byte_enable), .is_memory(is_memory),
    .last_beat(last_beat), .misaligned(misaligned)
  );

  address_generation_unit #(.XLEN(32), .BEAT_BYTES(4), .SPLIT_MISALIGNED(0)) dut_nosplit (
    .clk(clk), .reset(reset), .valid_in(valid_b), .ready_in(ready_in_b),
    .opcode(opcode), .funct3(funct3), .rs1(rs1), .PC(pc), .immediate(imm),
    .valid_out(valid_out_b), .ready_out(1'b1), .effective_address(ea_b),
    .address(address_b), .byte_enable(be_b), .is_memory(is_memory_b),
    .last_beat(last_beat_b), .misaligned(misaligned_b)
  );

  typedef struct packed {
    logic [31:0] ea;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        mem;
    logic        lst;
    logic        mis;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model for the split-mode, 4-byte-beat instance.
  function automatic void push_expected(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [31:0] r, input logic [31:0] p,
                                        input logic [31:0] i);
    beat_t       b;
    logic [31:0] ea;
    logic [15:0] m;
    int          n, off;
    bit          mem, ctrl;
    mem  = (op == OP_LOAD) || (op == OP_STORE);
    ctrl = (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
    if (!mem && !ctrl) return;
    ea = ((op == OP_JAL) || (op == OP_BRANCH)) ? p + i : r + i;
    if (op == OP_JALR) ea = ea & 32'hFFFF_FFFE;
    if (!mem) begin
      b = '{ea: ea, addr: ea, be: 4'h0, mem: 1'b0, lst: 1'b1, mis: (ea % 4) != 0};
      exp_q.push_back(b);
      return;
    end
    n   = 1 << int'(f3[1:0]);
    off = int'(ea % 4);
    m   = 16'(((1 << n) - 1) << off);
    b   = '{ea: ea, addr: ea & 32'hFFFF_FFFC, be: m[3:0], mem: 1'b1,
            lst: (off + n) <= 4, mis: (n == 8)};
    exp_q.push_back(b);
    if (off + n > 4) begin
      b.addr = (ea & 32'hFFFF_FFFC) + 32'd4;
      b.be   = m[7:4];
      b.lst  = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    bp_rand = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (reset && valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_ea",   effective_address, mon_e.ea);
        check("beat_addr", address,           mon_e.addr);
        check("beat_be",   byte_enable,       mon_e.be);
        check("beat_mem",  is_memory,         mon_e.mem);
        check("beat_last", last_beat,         mon_e.lst);
        check("beat_mis",  misaligned,        mon_e.mis);
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] r,
                      input logic [31:0] p, input logic [31:0] i);
    bit done = 0;
    opcode = op; funct3 = f3; rs1 = r; pc = p; imm = i; valid_in = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (ready_in) begin
        push_expected(op, f3, r, p, i);
        done = 1;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && (exp_q.size() != 0 || valid_out); c++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [6];
    ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_JAL;
    ops[3] = OP_JALR; ops[4] = OP_BRANCH; ops[5] = OP_OP;
    valid_in = 0; valid_b = 0; opcode = 0; funct3 = 0; rs1 = 0; pc = 0; imm = 0;
    ro_force = 1; bp_en = 0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_last_beat", last_beat, 0);
    check("rst_misaligned", misaligned, 0);
    check("rst_is_memory", is_memory, 0);
    check("rst_address", address, 0);
    check("rst_ea", effective_address, 0);
    check("rst_be", byte_enable, 0);
    check("rst_valid_out_b", valid_out_b, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("ready_in_after_reset", ready_in, 1);

    send(OP_LOAD, 3'd2, 32'h1000, 32'h0, 32'h4);
    check("lw_address", address, 32'h1004);
    check("lw_be", byte_enable, 4'b1111);
    check("lw_last", last_beat, 1);
    check("lw_mis", misaligned, 0);
    send(OP_STORE, 3'd1, 32'h2003, 32'h0, 32'h0);
    send(OP_JALR, 3'd0, 32'h3001, 32'h0, 32'h2);
    send(OP_JAL, 3'd0, 32'h0, 32'h100, 32'hFFFF_FFFE);
    send(OP_BRANCH, 3'd0, 32'h0, 32'h400, 32'h10);
    send(OP_LOAD, 3'd0, 32'h11, 32'h0, 32'h0);
    send(OP_LOAD, 3'd1, 32'h21, 32'h0, 32'h0);
    send(OP_LOAD, 3'd1, 32'h23, 32'h0, 32'h0);
    send(OP_LOAD, 3'd2, 32'h32, 32'h0, 32'h0);
    send(OP_LOAD, 3'd3, 32'h40, 32'h0, 32'h0);
    send(OP_LOAD, 3'd2, 32'hFFFF_FFFE, 32'h0, 32'h4);
    send(OP_STORE, 3'd6, 32'h51, 32'h0, 32'h0);
    drain();

    // Back-pressure on the first beat of a split store.
    ro_force = 0;
    send(OP_STORE, 3'd1, 32'h2003, 32'h0, 32'h0);
    valid_in = 1'b1; opcode = OP_LOAD; funct3 = 3'd2; rs1 = 32'h5000; imm = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", valid_out, 1);
      check("bp_addr", address, 32'h2000);
      check("bp_be", byte_enable, 4'b1000);
      check("bp_last", last_beat, 0);
      check("bp_ready_in", ready_in, 0);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; ro_force = 1;
    drain();

    // Reset while the second beat is pending.
    send(OP_STORE, 3'd1, 32'h2003, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("beat1_valid", valid_out, 1);
    check("beat1_addr", address, 32'h2004);
    reset = 1'b0;
    #1;
    check("midrst_valid", valid_out, 0);
    check("midrst_be", byte_enable, 0);
    exp_q.delete();
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    send(OP_OP, 3'd0, 32'h1234, 32'h0, 32'h8);
    repeat (2) begin
      @(negedge clk);
      check("op_no_beat", valid_out, 0);
    end
    check("op_ready_in", ready_in, 1);
    @(posedge clk); #1;

    bp_en = 1;
    for (int k = 0; k < 60; k++) begin
      send(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
           $urandom, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15)));
    end
    bp_en = 0;
    drain();

    // Non-split instance: the same straddling half-word is one flagged beat.
    valid_b = 1'b1; opcode = OP_STORE; funct3 = 3'd1; rs1 = 32'h2003; pc = 0; imm = 0;
    @(negedge clk);
    check("ns_ready_in", ready_in_b, 1);
    @(posedge clk); #1;
    valid_b = 1'b0;
    check("ns_valid", valid_out_b, 1);
    check("ns_ea", ea_b, 32'h2003);
    check("ns_addr", address_b, 32'h2000);
    check("ns_be", be_b, 4'b1000);
    check("ns_mis", misaligned_b, 1);
    check("ns_last", last_beat_b, 1);
    check("ns_mem", is_memory_b, 1);
    @(posedge clk); #1;
    check("ns_retired", valid_out_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
